load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane alignment: load extract/extend and sub-word store merge on a 32-bit word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    lane_b = rword[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? rword[31:16] : rword[15:0];
    case (size)
      BYTE:    load_data = {{24{sext & lane_b[7]}}, lane_b};
      HALF:    load_data = {{16{sext & lane_h[15]}}, lane_h};
      default: load_data = rword;
    endcase
  end

  // Replace only the addressed lane(s) of the read word with the store data.
  always_comb begin
    store_word = rword;
    case (size)
      BYTE: begin
        for (int unsigned n = 0; n < LANES; n++) begin
          if (offset == 2'(n)) store_word[8*n +: 8] = wdata[7:0];
        end
      end
      HALF: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end: request checking, RAM sequencing and response hold.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned data_length = 32,
  parameter int unsigned mem_length  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic                          req_signed,
  input  logic [31:0]                   req_addr,
  input  logic [data_length-1:0]        req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [data_length-1:0]        rsp_rdata,
  output logic                          rsp_err,
  output logic                          ram_we,
  output logic [$clog2(mem_length)-1:0] ram_address,
  output logic [data_length-1:0]        ram_write_data,
  input  logic [data_length-1:0]        ram_return_data
);

  localparam int unsigned AW         = $clog2(mem_length);
  localparam logic [32:0] BYTE_SPACE = 33'(4 * mem_length);

  state_t                 state_q, state_d;
  logic                   we_q, we_d;
  size_t                  size_q, size_d;
  logic                   sext_q, sext_d;
  logic [1:0]             off_q, off_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [data_length-1:0] wdata_q, wdata_d;
  logic [data_length-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   req_err;
  logic [31:0]            load_data;
  logic [31:0]            store_word;

  lsu_lane_align u_align (
    .rword      (ram_return_data),
    .offset     (off_q),
    .size       (size_q),
    .sext       (sext_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Reject illegal size, misalignment and out-of-range addresses at acceptance.
  always_comb begin
    req_err = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || ({1'b0, req_addr} >= BYTE_SPACE);
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= BYTE;
      sext_q  <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state sequencing; CAP either captures the load result or the merged store word.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = size_t'(req_size);
          sext_d  = req_signed;
          off_d   = req_addr[1:0];
          addr_d  = req_addr[AW+1:2];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)                          state_d = RESP;
          else if (req_we && req_size == 2'b10) state_d = WR;
          else                                  state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (we_q) begin
          wdata_d = store_word;
          state_d = WR;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WR:   state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready      = (state_q == IDLE) && !rst;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = (state_q == RESP) && err_q;
  assign ram_we         = (state_q == WR);
  assign ram_address    = addr_q;
  assign ram_write_data = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a byte-array model.
module tb_load_store_unit;

  localparam int MEMW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_we;
  logic [4:0]  ram_address;
  logic [31:0] ram_write_data, ram_return_data;

  load_store_unit #(.data_length(32), .mem_length(MEMW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .ram_we          (ram_we),
    .ram_address     (ram_address),
    .ram_write_data  (ram_write_data),
    .ram_return_data (ram_return_data)
  );

  always #5 clk = ~clk;

  // Word RAM with one-cycle registered read; also counts write pulses.
  logic [31:0] ram [MEMW];
  logic        ram_clear;
  int          we_count;
  logic [4:0]  last_we_addr;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < MEMW; i++) ram[i] <= '0;
    end else if (ram_we) begin
      ram[ram_address] <= ram_write_data;
      we_count         <= we_count + 1;
      last_we_addr     <= ram_address;
    end
    ram_return_data <= ram[ram_address];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference memory as bytes; byte address = index.
  logic [7:0] ref_mem [4*MEMW];

  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output int lat, output int wes);
    int nb;
    nb  = 1 << size;
    err = (size == 2'd3) || ((addr % nb) != 0) || (addr >= 4*MEMW);
    rd  = '0;
    wes = 0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[addr+i] = wdata[8*i +: 8];
      lat = (nb == 4) ? 2 : 4;
      wes = 1;
    end else begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[addr+i];
      if (sgn && nb < 4 && rd[8*nb-1])
        for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hFF;
      lat = 3;
    end
  endtask

  // One full request/response; hold = cycles rsp_ready stays low once rsp_valid is seen.
  task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, input string tag, output logic [31:0] got_rd);
    logic [31:0] erd;
    logic        eerr;
    int          elat, ewes, lat, wc0;
    model(we, size, sgn, addr, wdata, erd, eerr, elat, ewes);
    @(negedge clk);
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    rsp_ready  = (hold == 0);
    wc0        = we_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":lat"}, 32'(lat), 32'(elat));
    check({tag, ":rdata"}, rsp_rdata, erd);
    check({tag, ":err"}, 32'(rsp_err), 32'(eerr));
    got_rd = rsp_rdata;
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) @(negedge clk);
      if (k < hold) begin
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        if (k > 0) begin
          check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
          check({tag, ":hold_rdata"}, rsp_rdata, erd);
          check({tag, ":hold_err"}, 32'(rsp_err), 32'(eerr));
          check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
        end
      end else begin
        rsp_ready = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ":ready_after_hs"}, 32'(req_ready), 32'd1);
    check({tag, ":rsp_valid_low"}, 32'(rsp_valid), 32'd0);
    check({tag, ":we_pulses"}, 32'(we_count - wc0), 32'(ewes));
    if (ewes == 1) check({tag, ":we_addr"}, 32'(last_we_addr), 32'(addr[6:2]));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ":req_ready"}, 32'(req_ready), 32'd0);
    check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, ":rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, ":ram_we"}, 32'(ram_we), 32'd0);
    check({tag, ":ram_address"}, 32'(ram_address), 32'd0);
    check({tag, ":ram_write_data"}, ram_write_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeds limit 200000", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          wc0;
    logic        rwe, rsgn;
    logic [1:0]  rsz;
    logic [31:0] raddr;

    rst        = 1'b1;
    ram_clear  = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 4*MEMW; i++) ref_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst       = 1'b0;
    ram_clear = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, "st_w", rd);
    check("st_w:last_addr", 32'(last_we_addr), 32'd4);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "ld_w", rd);
    check("ld_w:value", rd, 32'hDEADBEEF);
    txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456A5, 0, "st_b", rd);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "ld_w2", rd);
    check("ld_w2:value", rd, 32'hDEADA5EF);
    txn(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, "ld_bs", rd);
    check("ld_bs:value", rd, 32'hFFFFFFA5);
    txn(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, "ld_bu", rd);
    check("ld_bu:value", rd, 32'h000000A5);
    txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, "ld_hs", rd);
    check("ld_hs:value", rd, 32'hFFFFDEAD);

    txn(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 0, "err_mis", rd);
    txn(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 0, "err_range", rd);
    txn(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, "err_size", rd);
    txn(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFFFFFF, 0, "err_st_mis", rd);
    txn(1'b1, 2'd0, 1'b0, 32'h7F, 32'h00000077, 0, "st_top", rd);

    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, "bp", rd);
    check("bp:value", rd, 32'hDEADA5EF);

    // Reset while the byte store sits in RD.
    @(negedge clk);
    wc0        = we_count;
    req_we     = 1'b1;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_wdata  = 32'h0000003C;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_rst:in_rd_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst:no_write", 32'(we_count - wc0), 32'd0);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "mid_rst_rb", rd);
    check("mid_rst_rb:value", rd, 32'hDEADA5EF);

    for (int t = 0; t < 40; t++) begin
      rwe   = 1'($urandom_range(0, 1));
      rsgn  = 1'($urandom_range(0, 1));
      rsz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      raddr = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) != 0 && rsz != 2'd3)
        raddr = raddr & ~((32'd1 << rsz) - 32'd1);
      if ($urandom_range(0, 15) == 0) raddr = raddr + 32'h80;
      txn(rwe, rsz, rsgn, raddr, $urandom, int'($urandom_range(0, 3)), $sformatf("rnd%0d", t), rd);
    end

    @(negedge clk);
    for (int w = 0; w < MEMW; w++)
      check($sformatf("ram%0d", w), ram[w],
            {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
